spi_reg_ctrl: RTL
=================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of SPI bytes and register data; command byte = {rw, addr[DATA_WIDTH-2:0]}.
REQ-002 Parameter: RD_TIMEOUT, 15, max i_clk cycles from o_reg_rd to i_reg_rvalid before timeout.
REQ-003 i_clk  in  1  single system clock, all logic on rising edge.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_rx_data  in  DATA_WIDTH  byte received from SPI slave.
REQ-006 i_rx_valid  in  1  one-cycle pulse, i_rx_data valid.
REQ-007 i_cs_n_sync  in  1  synchronized chip select, low = transaction active.
REQ-008 o_tx_data  out  DATA_WIDTH  next byte for SPI slave holding register.
REQ-009 o_tx_valid  out  1  load request; transfer occurs when o_tx_valid and i_tx_ready both high.
REQ-010 i_tx_ready  in  1  SPI slave holding register free.
REQ-011 o_reg_addr  out  DATA_WIDTH-1  register bus address.
REQ-012 o_reg_wdata  out  DATA_WIDTH  register write data.
REQ-013 o_reg_wr  out  1  one-cycle write strobe.
REQ-014 o_reg_rd  out  1  one-cycle read strobe.
REQ-015 i_reg_rdata  in  DATA_WIDTH  read data, valid with i_reg_rvalid.
REQ-016 i_reg_rvalid  in  1  one-cycle read completion pulse.
REQ-017 o_err  out  1  one-cycle pulse on read timeout.

Function
REQ-018 States: IDLE, CMD, WR_DATA, RD_REQ, RD_WAIT, RD_LOAD, RD_NEXT.
REQ-019 IDLE -> CMD when i_cs_n_sync low; CMD waits for first i_rx_valid of the transaction.
REQ-020 Command byte: bit DATA_WIDTH-1 = 1 read, 0 write; lower bits latched into o_reg_addr same cycle as i_rx_valid.
REQ-021 Write: CMD -> WR_DATA; each subsequent i_rx_valid drives o_reg_wr=1 and o_reg_wdata=i_rx_data exactly one cycle after i_rx_valid; address then increments (if auto-increment enabled).
REQ-022 Read: CMD -> RD_REQ; RD_REQ asserts o_reg_rd for one cycle -> RD_WAIT.
REQ-023 RD_WAIT: on i_reg_rvalid capture i_reg_rdata into o_tx_data -> RD_LOAD; after RD_TIMEOUT cycles without rvalid, o_tx_data=all-ones, o_err pulse, -> RD_LOAD.
REQ-024 RD_LOAD: hold o_tx_valid=1 with stable o_tx_data until i_tx_ready; on handshake deassert o_tx_valid next cycle -> RD_NEXT.
REQ-025 RD_NEXT: on i_rx_valid (dummy byte) increment address (if enabled) -> RD_REQ; received byte value ignored.
REQ-026 Byte N read data loaded during SPI byte N is shifted out during byte N+1 (one-byte turnaround).
REQ-027 Address arithmetic modulo 2^(DATA_WIDTH-1); 0x7F wraps to 0x00.
REQ-028 i_cs_n_sync high in any state -> IDLE next cycle; o_tx_valid, o_reg_rd, o_reg_wr cleared; a pending read is abandoned and a late i_reg_rvalid is ignored.
REQ-029 i_rx_valid coincident with i_cs_n_sync rising: byte processed only if state is WR_DATA (write completes), otherwise discarded.
REQ-030 i_rx_valid while in RD_REQ/RD_WAIT/RD_LOAD: byte discarded, no state change (master overrun, tx underflow handled by SPI slave).
REQ-031 o_reg_wr and o_reg_rd never asserted in the same cycle.

Reset
REQ-032 i_rst_n low: state IDLE, o_tx_data=0, o_tx_valid=0, o_reg_addr=0, o_reg_wdata=0, o_reg_wr=0, o_reg_rd=0, o_err=0, timeout counter=0, immediately and asynchronously.
REQ-033 Reset mid-transaction: no strobe emitted after release until a new command byte following fresh CS assertion.

Configuration
REQ-034 Macro SPI_REG_CTRL_AUTOINC_EN defined: address increments after each write byte and before each subsequent read.
REQ-035 SPI_REG_CTRL_AUTOINC_EN undefined: address stays fixed for whole transaction (repeated access to one register, FIFO-style).

Verification
REQ-036 CS low, bytes 0x05,0xA1,0xB2 -> o_reg_wr at addr 0x05 data 0xA1, addr 0x06 data 0xB2 (autoinc on).
REQ-037 CS low, bytes 0x83,0x00,0x00, rdata=0x3C then 0x4D after 2 cycles -> o_reg_rd at 0x03, 0x04; o_tx_data 0x3C then 0x4D via handshake.
REQ-038 Read 0x90, i_reg_rvalid never asserted -> o_err pulse RD_TIMEOUT cycles after o_reg_rd, o_tx_data=0xFF.
REQ-039 Write starting at 0x7F, two data bytes -> addresses 0x7F then 0x00.
REQ-040 CS high during RD_WAIT, then rvalid -> IDLE next cycle, o_tx_valid stays 0; macro undefined, bytes 0x05,0x11,0x22 -> both writes to 0x05.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI byte-stream to register-bus bridge: command byte {rw, addr}, then write data or read dummies.
// Define SPI_REG_CTRL_AUTOINC_EN to advance the address after each write and before each later read.
module spi_reg_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_cs_n_sync,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [DATA_WIDTH-2:0] o_reg_addr,
    output logic [DATA_WIDTH-1:0] o_reg_wdata,
    output logic                  o_reg_wr,
    output logic                  o_reg_rd,
    input  logic [DATA_WIDTH-1:0] i_reg_rdata,
    input  logic                  i_reg_rvalid,
    output logic                  o_err
);

    localparam int unsigned AW = DATA_WIDTH - 1;
    localparam int unsigned CW = $clog2(RD_TIMEOUT + 1);
`ifdef SPI_REG_CTRL_AUTOINC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle, StCmd, StWrData, StRdReq, StRdWait, StRdLoad, StRdNext
    } state_e;

    state_e                state_q;
    logic [AW-1:0]         addr_q;
    logic [AW-1:0]         addr_inc;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_valid_q;
    logic                  wr_q;
    logic                  rd_q;
    logic                  err_q;
    logic [CW-1:0]         cnt_q;

    // Natural AW-bit overflow gives the modulo-2^AW wrap.
    assign addr_inc = AutoInc ? addr_q + AW'(1) : addr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            err_q <= 1'b0;
            // Address moves on once the write strobe has been presented.
            if (wr_q) begin
                addr_q <= addr_inc;
            end
            if (i_cs_n_sync) begin
                state_q    <= StIdle;
                tx_valid_q <= 1'b0;
                cnt_q      <= '0;
                // A data byte landing on the CS edge still completes its write.
                if (state_q == StWrData && i_rx_valid) begin
                    wr_q    <= 1'b1;
                    wdata_q <= i_rx_data;
                end
            end else begin
                unique case (state_q)
                    StIdle: state_q <= StCmd;
                    StCmd: begin
                        if (i_rx_valid) begin
                            addr_q  <= i_rx_data[AW-1:0];
                            state_q <= i_rx_data[DATA_WIDTH-1] ? StRdReq : StWrData;
                        end
                    end
                    StWrData: begin
                        if (i_rx_valid) begin
                            wr_q    <= 1'b1;
                            wdata_q <= i_rx_data;
                        end
                    end
                    StRdReq: begin
                        rd_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StRdWait;
                    end
                    StRdWait: begin
                        if (i_reg_rvalid) begin
                            tx_data_q  <= i_reg_rdata;
                            tx_valid_q <= 1'b1;
                            state_q    <= StRdLoad;
                        end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
                            tx_data_q  <= '1;
                            tx_valid_q <= 1'b1;
                            err_q      <= 1'b1;
                            state_q    <= StRdLoad;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    StRdLoad: begin
                        if (i_tx_ready) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= StRdNext;
                        end
                    end
                    StRdNext: begin
                        if (i_rx_valid) begin
                            addr_q  <= addr_inc;
                            state_q <= StRdReq;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_wr    = wr_q;
    assign o_reg_rd    = rd_q;
    assign o_err       = err_q;

endmodule
